nat_lookup_sched: RTL

// Front-end scheduler for the NAT connection hash engine. It buffers tuples from the TX (egress) and RX (ingress)

---
 rtl/nat_lookup_sched_if.sv | 49 ++++
 rtl/nat_lookup_sched.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/nat_lookup_sched_if.sv
`default_nettype none
// ============================================================================
//  Module      : nat_lookup_sched_if
//  Description : Request/response and engine-side bundle of the NAT lookup
//                scheduler. "slave" is the scheduler's view; "master" is the
//                view of the parsers, the engine and the response consumers.
//  Revision    : 1.0 - initial release
// ============================================================================
interface nat_lookup_sched_if;
    logic [127:0] tx_req_data;
    logic         tx_req_valid;
    logic         tx_req_ready;
    logic [15:0]  tx_resp_data;
    logic         tx_resp_valid;

    logic [127:0] rx_req_data;
    logic         rx_req_valid;
    logic         rx_req_ready;
    logic [15:0]  rx_resp_data;
    logic         rx_resp_valid;
    logic         rx_resp_miss;

    logic [127:0] eng_tuple_data;
    logic         eng_valid_0;
    logic         eng_valid_1;
    logic [15:0]  eng_conn_data_0;
    logic         eng_conn_valid_0;
    logic [15:0]  eng_conn_data_1;
    logic         eng_conn_valid_1;

    logic         timeout_err;

    modport slave (
        input  tx_req_data, tx_req_valid, rx_req_data, rx_req_valid,
        input  eng_conn_data_0, eng_conn_valid_0, eng_conn_data_1, eng_conn_valid_1,
        output tx_req_ready, tx_resp_data, tx_resp_valid,
        output rx_req_ready, rx_resp_data, rx_resp_valid, rx_resp_miss,
        output eng_tuple_data, eng_valid_0, eng_valid_1, timeout_err
    );

    modport master (
        output tx_req_data, tx_req_valid, rx_req_data, rx_req_valid,
        output eng_conn_data_0, eng_conn_valid_0, eng_conn_data_1, eng_conn_valid_1,
        input  tx_req_ready, tx_resp_data, tx_resp_valid,
        input  rx_req_ready, rx_resp_data, rx_resp_valid, rx_resp_miss,
        input  eng_tuple_data, eng_valid_0, eng_valid_1, timeout_err
    );
endinterface
`default_nettype wire

// File: rtl/nat_lookup_sched.sv
`default_nettype none
// ============================================================================
//  Module      : nat_lookup_sched
//  Description : Front-end scheduler for the NAT connection hash engine.
//                Buffers TX/RX tuples in per-side FIFOs, arbitrates
//                round-robin, keeps one lookup outstanding, forces a miss on
//                timeout and idles for a guard window after each TX result.
//  Revision    : 1.0 - initial release
// ============================================================================
module nat_lookup_sched #(
    parameter int FIFO_DEPTH   = 4,
    parameter int TIMEOUT      = 255,
    parameter int GUARD_CYCLES = 70
) (
    input  logic               clk,
    input  logic               reset,
    nat_lookup_sched_if.slave  bus
);
    localparam int c_addr_w  = $clog2(FIFO_DEPTH);
    localparam int c_guard_w = $clog2(GUARD_CYCLES + 1);
    localparam int c_cnt_w   = (c_guard_w > 8) ? c_guard_w : 8;

    localparam logic [c_cnt_w-1:0] c_timeout    = c_cnt_w'(TIMEOUT);
    localparam logic [c_cnt_w-1:0] c_guard_last = c_cnt_w'(GUARD_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_max    = '1;

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_issue = 2'd1;
    localparam logic [1:0] c_st_wait  = 2'd2;
    localparam logic [1:0] c_st_guard = 2'd3;

    localparam logic c_side_tx = 1'b0;
    localparam logic c_side_rx = 1'b1;

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic               r_side;          // side of the lookup in flight
    logic               r_prio;          // side preferred when both FIFOs wait
    logic [c_cnt_w-1:0] r_cnt;           // WAIT timeout / GUARD length counter
    logic [127:0]       r_tuple;
    logic [15:0]        r_tx_resp_data;
    logic               r_tx_resp_valid;
    logic [15:0]        r_rx_resp_data;
    logic               r_rx_resp_valid;
    logic               r_rx_resp_miss;
    logic               r_timeout_err;

    logic [1:0]         w_push;
    logic [1:0]         w_pop;
    logic [1:0]         w_full;
    logic [1:0]         w_empty;
    logic [127:0]       w_req_data [2];
    logic [127:0]       w_head [2];
    logic               w_grant_valid;
    logic               w_grant_side;
    logic               w_both;
    logic               w_hit;
    logic               w_timeout;

    // Ready is forced low while reset is held so nothing is offered to a flushing FIFO.
    assign bus.tx_req_ready = reset & ~w_full[0];
    assign bus.rx_req_ready = reset & ~w_full[1];
    assign w_push           = {bus.rx_req_valid & bus.rx_req_ready,
                               bus.tx_req_valid & bus.tx_req_ready};
    assign w_req_data[0]    = bus.tx_req_data;
    assign w_req_data[1]    = bus.rx_req_data;

    generate
        for (genvar g = 0; g < 2; g++) begin : g_fifo
            logic [127:0]      r_mem [FIFO_DEPTH];
            logic [c_addr_w:0] r_wr_ptr;
            logic [c_addr_w:0] r_rd_ptr;

            // Pointers carry one wrap bit so full and empty are distinguishable.
            always_ff @(posedge clk) begin
                if (!reset) begin
                    r_wr_ptr <= '0;
                    r_rd_ptr <= '0;
                end else begin
                    if (w_push[g]) begin
                        r_mem[r_wr_ptr[c_addr_w-1:0]] <= w_req_data[g];
                        r_wr_ptr <= r_wr_ptr + (c_addr_w+1)'(1);
                    end
                    if (w_pop[g]) begin
                        r_rd_ptr <= r_rd_ptr + (c_addr_w+1)'(1);
                    end
                end
            end

            assign w_empty[g] = (r_wr_ptr == r_rd_ptr);
            assign w_full[g]  = (r_wr_ptr[c_addr_w] != r_rd_ptr[c_addr_w]) &&
                                (r_wr_ptr[c_addr_w-1:0] == r_rd_ptr[c_addr_w-1:0]);
            assign w_head[g]  = r_mem[r_rd_ptr[c_addr_w-1:0]];
        end
    endgenerate

    // Choose the side to serve: the only non-empty one, or the preferred one when both wait.
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_side  = c_side_tx;
        w_both        = 1'b0;
        if (!w_empty[0] && !w_empty[1]) begin
            w_grant_valid = 1'b1;
            w_grant_side  = r_prio;
            w_both        = 1'b1;
        end else if (!w_empty[0]) begin
            w_grant_valid = 1'b1;
            w_grant_side  = c_side_tx;
        end else if (!w_empty[1]) begin
            w_grant_valid = 1'b1;
            w_grant_side  = c_side_rx;
        end
    end

    assign w_pop     = (r_state == c_st_idle && w_grant_valid) ?
                       ((w_grant_side == c_side_rx) ? 2'b10 : 2'b01) : 2'b00;
    // Only the channel of the lookup in flight can complete it.
    assign w_hit     = (r_side == c_side_tx) ? bus.eng_conn_valid_0 : bus.eng_conn_valid_1;
    assign w_timeout = (r_cnt >= c_timeout);

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: IDLE -> ISSUE -> WAIT -> GUARD (TX hit) or IDLE.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle:  if (w_grant_valid) w_state_next = c_st_issue;
            c_st_issue: w_state_next = c_st_wait;
            c_st_wait: begin
                if (w_hit) begin
                    w_state_next = (r_side == c_side_tx) ? c_st_guard : c_st_idle;
                end else if (w_timeout) begin
                    w_state_next = c_st_idle;
                end
            end
            c_st_guard: if (r_cnt >= c_guard_last) w_state_next = c_st_idle;
            default:    w_state_next = c_st_idle;
        endcase
    end

    // Issue strobes: one cycle in ISSUE on the granted side's channel.
    always_comb begin
        bus.eng_valid_0 = 1'b0;
        bus.eng_valid_1 = 1'b0;
        if (r_state == c_st_issue) begin
            bus.eng_valid_0 = (r_side == c_side_tx);
            bus.eng_valid_1 = (r_side == c_side_rx);
        end
    end

    // Tuple latch, arbitration bookkeeping, shared counter and registered responses.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_tuple         <= '0;
            r_side          <= c_side_tx;
            r_prio          <= c_side_tx;
            r_cnt           <= '0;
            r_tx_resp_data  <= '0;
            r_tx_resp_valid <= 1'b0;
            r_rx_resp_data  <= '0;
            r_rx_resp_valid <= 1'b0;
            r_rx_resp_miss  <= 1'b0;
            r_timeout_err   <= 1'b0;
        end else begin
            r_tx_resp_valid <= 1'b0;
            r_rx_resp_valid <= 1'b0;
            r_rx_resp_miss  <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (w_grant_valid) begin
                        r_tuple <= w_head[w_grant_side];
                        r_side  <= w_grant_side;
                        // Priority only rotates when there was an actual contest.
                        if (w_both) r_prio <= ~w_grant_side;
                    end
                end
                c_st_issue: r_cnt <= '0;
                c_st_wait: begin
                    if (w_hit) begin
                        r_cnt <= '0;
                        if (r_side == c_side_tx) begin
                            r_tx_resp_valid <= 1'b1;
                            r_tx_resp_data  <= bus.eng_conn_data_0;
                        end else begin
                            r_rx_resp_valid <= 1'b1;
                            r_rx_resp_data  <= bus.eng_conn_data_1;
                        end
                    end else if (w_timeout) begin
                        r_timeout_err <= 1'b1;
                        if (r_side == c_side_tx) begin
                            r_tx_resp_valid <= 1'b1;
                            r_tx_resp_data  <= '0;
                        end else begin
                            r_rx_resp_valid <= 1'b1;
                            r_rx_resp_miss  <= 1'b1;
                            r_rx_resp_data  <= '0;
                        end
                    end else if (r_cnt != c_cnt_max) begin
                        r_cnt <= r_cnt + c_cnt_w'(1);
                    end
                end
                c_st_guard: begin
                    if (r_cnt != c_cnt_max) r_cnt <= r_cnt + c_cnt_w'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.eng_tuple_data = r_tuple;
    assign bus.tx_resp_data   = r_tx_resp_data;
    assign bus.tx_resp_valid  = r_tx_resp_valid;
    assign bus.rx_resp_data   = r_rx_resp_data;
    assign bus.rx_resp_valid  = r_rx_resp_valid;
    assign bus.rx_resp_miss   = r_rx_resp_miss;
    assign bus.timeout_err    = r_timeout_err;

endmodule
`default_nettype wire
